// File: rtl/ogr_pkg.sv
// OGR job link shared definitions.
// Frame lengths, field offsets and status codes.
package ogr_pkg;

  localparam int OGR_REQ_BYTES = 6;
  localparam int OGR_RSP_BYTES = 8;

  localparam int OGR_MAXD_W  = 16;
  localparam int OGR_MIND_W  = 16;
  localparam int OGR_MARKS_W = 32;

  localparam int OGR_REQ_MAXD_LSB  = 32;
  localparam int OGR_REQ_MARKS_LSB = 0;
  localparam int OGR_RSP_MAXD_LSB  = 48;
  localparam int OGR_RSP_MIND_LSB  = 32;
  localparam int OGR_RSP_MARKS_LSB = 0;

  typedef enum logic [1:0] {
    OGR_ST_OK      = 2'd0,
    OGR_ST_ECHO    = 2'd1,
    OGR_ST_TIMEOUT = 2'd2,
    OGR_ST_RXERR   = 2'd3
  } ogr_status_e;

  function automatic logic ogr_echo_ok(
    input logic [47:0] req,
    input logic [63:0] rsp
  );
    logic maxd_ok;
    logic marks_ok;
    maxd_ok = rsp[OGR_RSP_MAXD_LSB +: OGR_MAXD_W]
           == req[OGR_REQ_MAXD_LSB +: OGR_MAXD_W];
    marks_ok = rsp[OGR_RSP_MARKS_LSB +: OGR_MARKS_W]
            == req[OGR_REQ_MARKS_LSB +: OGR_MARKS_W];
    return maxd_ok && marks_ok;
  endfunction

endpackage

// File: rtl/ogr_frame_master_if.sv
// Byte-side link between the frame master and its uart.
// master drives transmit requests, slave is the uart.
interface ogr_frame_master_if;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       is_transmitting;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;

  modport master (
    output transmit,
    output tx_byte,
    input  is_transmitting,
    input  received,
    input  rx_byte,
    input  recv_error
  );

  modport slave (
    input  transmit,
    input  tx_byte,
    output is_transmitting,
    output received,
    output rx_byte,
    output recv_error
  );
endinterface

// File: rtl/ogr_rx_timeout.sv
// Reloadable down-counter guarding the gap between response bytes.
// expired rises so that done lands CYCLES cycles after the last reload.
module ogr_rx_timeout #(
  parameter int unsigned CYCLES = 12000000
) (
  input  logic iCE_CLK,
  input  logic rst_n,
  input  logic reload,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  localparam int unsigned LOAD_I =
    (CYCLES > 2) ? CYCLES - 2 : 0;
  localparam logic [W-1:0] LOAD = LOAD_I[W-1:0];

  logic [W-1:0] cnt_q;

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (reload) begin
      cnt_q <= LOAD;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);
endmodule

// File: rtl/ogr_frame_master.sv
// OGR job link initiator: sends the 6-byte request,
// collects the 8-byte response and checks the echo.
module ogr_frame_master
  import ogr_pkg::*;
#(
  parameter int          REQ_BYTES      = OGR_REQ_BYTES,
  parameter int          RSP_BYTES      = OGR_RSP_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
  input  logic        iCE_CLK,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] req_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [63:0] rsp_data,
  ogr_frame_master_if.master uart
);
  localparam int CNT_MAX =
    (REQ_BYTES > RSP_BYTES) ? REQ_BYTES : RSP_BYTES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_BYTES);
  localparam logic [CW-1:0] RSP_LAST = CW'(RSP_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_ISSUE,
    S_TX_ACK,
    S_TX_DRAIN,
    S_RX,
    S_CHECK,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [47:0] req_q;
  logic [63:0] rsp_q;
  ogr_status_e status_q, st_val;

  logic accept, cnt_inc, cnt_clr, store;
  logic tmo_reload, tmo_en, tmo_expired;
  logic st_set;

  ogr_rx_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .iCE_CLK (iCE_CLK),
    .rst_n   (rst_n),
    .reload  (tmo_reload),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    cnt_inc       = 1'b0;
    cnt_clr       = 1'b0;
    store         = 1'b0;
    tmo_reload    = 1'b0;
    tmo_en        = 1'b0;
    st_set        = 1'b0;
    st_val        = OGR_ST_OK;
    done          = 1'b0;
    uart.transmit = 1'b0;
    uart.tx_byte  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          tmo_reload = 1'b1;
          state_d    = S_TX_ISSUE;
        end
      end
      S_TX_ISSUE: begin
        if (!uart.is_transmitting) begin
          uart.transmit = 1'b1;
          uart.tx_byte  =
            req_q[8*(REQ_BYTES-1-int'(cnt_q)) +: 8];
          state_d       = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (uart.is_transmitting) begin
          cnt_inc = 1'b1;
          state_d = S_TX_DRAIN;
        end
      end
      S_TX_DRAIN: begin
        if (!uart.is_transmitting) begin
          if (cnt_q == REQ_LAST) begin
            cnt_clr = 1'b1;
            state_d = S_RX;
          end else begin
            state_d = S_TX_ISSUE;
          end
        end
      end
      S_RX: begin
        tmo_en = 1'b1;
        // a byte landing on the expiry cycle still wins
        if (uart.recv_error) begin
          st_set  = 1'b1;
          st_val  = OGR_ST_RXERR;
          state_d = S_DONE;
        end else if (uart.received) begin
          store      = 1'b1;
          cnt_inc    = 1'b1;
          tmo_reload = 1'b1;
          if (cnt_q == RSP_LAST) state_d = S_CHECK;
        end else if (tmo_expired) begin
          st_set  = 1'b1;
          st_val  = OGR_ST_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_CHECK: begin
        st_set  = 1'b1;
        st_val  = ogr_echo_ok(req_q, rsp_q)
                ? OGR_ST_OK : OGR_ST_ECHO;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      rsp_q    <= '0;
      status_q <= OGR_ST_OK;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= req_data;
        rsp_q <= '0;
        cnt_q <= '0;
      end else if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (store) begin
        rsp_q[8*(RSP_BYTES-1-int'(cnt_q)) +: 8]
          <= uart.rx_byte;
      end
      if (st_set) status_q <= st_val;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign status   = status_q;
  assign rsp_data = rsp_q;
endmodule

// File: tb/tb_ogr_frame_master.sv
// Directed bench for ogr_frame_master with a small uart model.
// Loopback, echo error, timeout, rx error, ignored inputs, reset.
module tb_ogr_frame_master;
  import ogr_pkg::*;

  localparam int unsigned TMO = 100;

  logic        iCE_CLK = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic [47:0] req_data = '0;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [63:0] rsp_data;

  ogr_frame_master_if uif ();

  ogr_frame_master #(
    .REQ_BYTES      (6),
    .RSP_BYTES      (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .iCE_CLK  (iCE_CLK),
    .rst_n    (rst_n),
    .start    (start),
    .req_data (req_data),
    .busy     (busy),
    .done     (done),
    .status   (status),
    .rsp_data (rsp_data),
    .uart     (uif.master)
  );

  always #5 iCE_CLK = ~iCE_CLK;

  int n_run    = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int tx_dbl   = 0;
  int tx_left  = 0;
  logic prev_tx = 1'b0;
  logic [7:0] txq [$];

  // uart model: accepts a byte, busy for three cycles
  always @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      uif.is_transmitting = 1'b0;
      tx_left = 0;
    end else begin
      logic       fire;
      logic [7:0] b;
      fire = uif.transmit;
      b    = uif.tx_byte;
      #2;
      if (fire) begin
        txq.push_back(b);
        tx_left = 3;
        uif.is_transmitting = 1'b1;
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) uif.is_transmitting = 1'b0;
      end
    end
  end

  always @(negedge iCE_CLK) begin
    if (done) done_cnt++;
    if (uif.transmit && prev_tx) tx_dbl++;
    prev_tx = uif.transmit;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCE_CLK);
    #1;
  endtask

  task automatic start_job(input logic [47:0] r);
    tick();
    start    = 1'b1;
    req_data = r;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (txq.size() < n && k < 400) begin
      tick();
      k++;
    end
  endtask

  task automatic send_rx(
    input logic [7:0] b,
    input logic       err
  );
    tick();
    uif.received   = ~err;
    uif.recv_error = err;
    uif.rx_byte    = b;
    tick();
    uif.received   = 1'b0;
    uif.recv_error = 1'b0;
  endtask

  task automatic run_rsp(
    input logic [63:0] rsp,
    input int          nb
  );
    for (int j = 0; j < nb; j++) begin
      send_rx(rsp[63-8*j -: 8], 1'b0);
    end
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 400) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [47:0] txword();
    logic [47:0] w;
    w = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < txq.size()) w = {w[39:0], txq[i]};
      else                w = {w[39:0], 8'hxx};
    end
    return w;
  endfunction

  task automatic send_req(input logic [47:0] r);
    txq.delete();
    start_job(r);
    wait_tx(6);
    repeat (6) tick();
    chk("tx_bytes", 64'(txword()), 64'(r));
  endtask

  initial begin
    int n;
    int d0;
    uif.received   = 1'b0;
    uif.recv_error = 1'b0;
    uif.rx_byte    = '0;
    repeat (3) @(posedge iCE_CLK);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_rsp", rsp_data, 64'd0);
    chk("rst_transmit", 64'(uif.transmit), 64'd0);
    chk("rst_tx_byte", 64'(uif.tx_byte), 64'd0);
    rst_n = 1'b1;
    tick();

    // loopback
    txq.delete();
    d0 = done_cnt;
    start_job(48'h0064_0102_0304);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_tx_first", 64'(uif.transmit), 64'd1);
    wait_tx(6);
    repeat (6) tick();
    chk("t1_tx_bytes", 64'(txword()),
        64'h0064_0102_0304);
    run_rsp(64'h0064_0000_0102_0304, 8);
    wait_done(n);
    chk("t1_latency", 64'(n), 64'd2);
    chk("t1_status", 64'(status), 64'(OGR_ST_OK));
    chk("t1_rsp", rsp_data, 64'h0064_0000_0102_0304);
    tick();
    chk("t1_done_low", 64'(done), 64'd0);
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

    // echo mismatch
    send_req(48'h0064_0102_0304);
    run_rsp(64'h0064_0000_0102_0305, 8);
    wait_done(n);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_status", 64'(status), 64'(OGR_ST_ECHO));
    chk("t2_rsp_lsb", 64'(rsp_data[7:0]), 64'h05);

    // timeout after three bytes
    send_req(48'h0064_0102_0304);
    run_rsp(64'h0064_0000_0000_0000, 3);
    wait_done(n);
    chk("t3_latency", 64'(n), 64'(TMO));
    chk("t3_status", 64'(status), 64'(OGR_ST_TIMEOUT));
    chk("t3_rsp", rsp_data, 64'h0064_0000_0000_0000);

    // receive error after four bytes
    send_req(48'h0064_0102_0304);
    run_rsp(64'h0064_0007_0000_0000, 4);
    send_rx(8'h00, 1'b1);
    wait_done(n);
    chk("t4_latency", 64'(n), 64'd1);
    chk("t4_status", 64'(status), 64'(OGR_ST_RXERR));
    chk("t4_rsp", rsp_data, 64'h0064_0007_0000_0000);
    tick();

    // reset during the second request byte
    txq.delete();
    d0 = done_cnt;
    start_job(48'h0020_1122_3344);
    wait_tx(2);
    #4;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_status", 64'(status), 64'd0);
    chk("t5_rsp", rsp_data, 64'd0);
    chk("t5_transmit", 64'(uif.transmit), 64'd0);
    chk("t5_tx_byte", 64'(uif.tx_byte), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    send_req(48'h0020_1122_3344);
    run_rsp(64'h0020_0007_1122_3344, 8);
    wait_done(n);
    chk("t5_clean_lat", 64'(n), 64'd2);
    chk("t5_clean_st", 64'(status), 64'(OGR_ST_OK));
    chk("t5_clean_rsp", rsp_data,
        64'h0020_0007_1122_3344);
    tick();

    // start and received injected during tx
    txq.delete();
    d0 = done_cnt;
    start_job(48'h0011_AABB_CCDD);
    wait_tx(1);
    start    = 1'b1;
    req_data = 48'hFFFF_FFFF_FFFF;
    tick();
    start    = 1'b0;
    send_rx(8'hFF, 1'b0);
    wait_tx(6);
    repeat (6) tick();
    chk("t6_tx_bytes", 64'(txword()),
        64'h0011_AABB_CCDD);
    run_rsp(64'h0011_1234_AABB_CCDD, 8);
    wait_done(n);
    chk("t6_status", 64'(status), 64'(OGR_ST_OK));
    chk("t6_rsp", rsp_data, 64'h0011_1234_AABB_CCDD);
    repeat (20) tick();
    chk("t6_idle", 64'(busy), 64'd0);
    chk("t6_tx_count", 64'(txq.size()), 64'd6);
    chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);

    chk("tx_back2back", 64'(tx_dbl), 64'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end
endmodule
